// File: rtl/mac_acc_quant_if.sv
// Stream bundle between the MAC product stage, the accumulate/quantise stage and its consumer.
// The slave modport is the view of mac_acc_quant; the master modport is the view of its environment.
interface mac_acc_quant_if #(
   parameter int PW    = 28,
   parameter int OW    = 14,
   parameter int CNT_W = 16
) ();
   logic signed [PW-1:0]    s_product;
   logic                    s_valid;
   logic                    s_last;
   logic                    s_ready;
   logic        [OW-1:0]    m_data;
   logic                    m_sat;
   logic        [CNT_W-1:0] m_count;
   logic                    m_valid;
   logic                    m_ready;

   modport slave (
      input  s_product, s_valid, s_last, m_ready,
      output s_ready, m_data, m_sat, m_count, m_valid
   );

   modport master (
      output s_product, s_valid, s_last, m_ready,
      input  s_ready, m_data, m_sat, m_count, m_valid
   );
endinterface

// File: rtl/mac_acc_quant.sv
// Accumulates a frame of signed products, then rounds/truncates and saturates to a narrow Q word.
// Optional feature macro: MAC_ACC_ROUND_EN (round half-up before the shift; default build truncates).
module mac_acc_quant #(
   parameter int int_a     = 6,
   parameter int frac_a    = 8,
   parameter int int_b     = 6,
   parameter int frac_b    = 8,
   parameter int out_int   = 6,
   parameter int out_frac  = 8,
   parameter int ACC_GUARD = 8,
   parameter int CNT_W     = 16
) (
   input  logic          clock,
   input  logic          rstn,
   mac_acc_quant_if.slave bus
);
   localparam int PW = int_a + frac_a + int_b + frac_b;
   localparam int AW = PW + ACC_GUARD;
   localparam int OW = out_int + out_frac;
   localparam int SH = frac_a + frac_b - out_frac;
`ifdef MAC_ACC_ROUND_EN
   localparam int QW     = AW + 1;
   localparam int RND_SH = (SH > 0) ? SH - 1 : 0;
   localparam logic [QW-1:0] RND_K = (SH > 0) ? ({{(QW-1){1'b0}}, 1'b1} << RND_SH) : {QW{1'b0}};
`else
   localparam int QW = AW;
`endif

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_ACCUM = 1'b1;

   localparam logic [AW-1:0]    ACC_MAX = {1'b0, {(AW-1){1'b1}}};
   localparam logic [AW-1:0]    ACC_MIN = {1'b1, {(AW-1){1'b0}}};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   // Returns {clipped, word}: the value fits only if every bit above the output sign matches it.
   function automatic logic [OW:0] sat_ow(input logic [QW-1:0] v);
      logic [QW-OW:0] hi;
      hi = v[QW-1:OW-1];
      if ((&hi) || (~|hi)) begin
         sat_ow = {1'b0, v[OW-1:0]};
      end else if (v[QW-1]) begin
         sat_ow = {1'b1, 1'b1, {(OW-1){1'b0}}};
      end else begin
         sat_ow = {1'b1, 1'b0, {(OW-1){1'b1}}};
      end
   endfunction

   logic [0:0]       state_q, state_d;
   logic [AW-1:0]    acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic [OW-1:0]    m_data_q, m_data_d;
   logic             m_sat_q, m_sat_d;
   logic [CNT_W-1:0] m_count_q, m_count_d;
   logic             m_valid_q, m_valid_d;

   logic             s_ready_s;
   logic             hs_s;
   logic             first_s;
   logic [AW-1:0]    prod_ext_s;
   logic [AW-1:0]    base_s;
   logic [AW-1:0]    sum_raw_s;
   logic             add_ovf_s;
   logic [AW-1:0]    sum_s;
   logic             ovf_next_s;
   logic [CNT_W-1:0] cnt_next_s;
   logic [QW-1:0]    rnd_s;
   logic [QW-1:0]    shf_s;
   logic             clip_s;
   logic [OW-1:0]    qdata_s;

   // Handshake, accumulate with clamp-on-overflow, and beat counting.
   always_comb begin
      s_ready_s  = !m_valid_q || bus.m_ready;
      hs_s       = bus.s_valid && s_ready_s;
      first_s    = (state_q == ST_IDLE);
      prod_ext_s = {{ACC_GUARD{bus.s_product[PW-1]}}, bus.s_product};
      if (first_s) begin
         base_s = {AW{1'b0}};
      end else begin
         base_s = acc_q;
      end
      sum_raw_s = base_s + prod_ext_s;
      add_ovf_s = (base_s[AW-1] == prod_ext_s[AW-1]) && (sum_raw_s[AW-1] != base_s[AW-1]);
      if (!add_ovf_s) begin
         sum_s = sum_raw_s;
      end else if (prod_ext_s[AW-1]) begin
         sum_s = ACC_MIN;
      end else begin
         sum_s = ACC_MAX;
      end
      ovf_next_s = add_ovf_s || (!first_s && ovf_q);
      if (first_s) begin
         cnt_next_s = CNT_ONE;
      end else if (cnt_q == CNT_MAX) begin
         cnt_next_s = cnt_q;
      end else begin
         cnt_next_s = cnt_q + CNT_ONE;
      end
   end

   // Quantisation of the running sum; only used when the beat closes the frame.
   always_comb begin
`ifdef MAC_ACC_ROUND_EN
      rnd_s = {sum_s[AW-1], sum_s} + RND_K;
`else
      rnd_s = sum_s;
`endif
      shf_s             = $signed(rnd_s) >>> SH;
      {clip_s, qdata_s} = sat_ow(shf_s);
   end

   // Next-state for the frame FSM and the output register.
   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      ovf_d     = ovf_q;
      m_data_d  = m_data_q;
      m_sat_d   = m_sat_q;
      m_count_d = m_count_q;
      m_valid_d = m_valid_q;
      if (hs_s) begin
         cnt_d = cnt_next_s;
         ovf_d = ovf_next_s;
         if (bus.s_last) begin
            state_d   = ST_IDLE;
            acc_d     = {AW{1'b0}};
            m_data_d  = qdata_s;
            m_sat_d   = clip_s || ovf_next_s;
            m_count_d = cnt_next_s;
            m_valid_d = 1'b1;
         end else begin
            state_d = ST_ACCUM;
            acc_d   = sum_s;
         end
      end else begin
         state_d = state_q;
      end
      // A retiring beat frees the register unless a new result loaded above.
      if (!(hs_s && bus.s_last)) begin
         if (bus.m_ready) begin
            m_valid_d = 1'b0;
         end else begin
            m_valid_d = m_valid_q;
         end
      end else begin
         m_valid_d = 1'b1;
      end
   end

   // State and output registers; reset drops any partial frame.
   always_ff @(posedge clock or negedge rstn) begin
      if (!rstn) begin
         state_q   <= ST_IDLE;
         acc_q     <= {AW{1'b0}};
         cnt_q     <= {CNT_W{1'b0}};
         ovf_q     <= 1'b0;
         m_data_q  <= {OW{1'b0}};
         m_sat_q   <= 1'b0;
         m_count_q <= {CNT_W{1'b0}};
         m_valid_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         ovf_q     <= ovf_d;
         m_data_q  <= m_data_d;
         m_sat_q   <= m_sat_d;
         m_count_q <= m_count_d;
         m_valid_q <= m_valid_d;
      end
   end

   assign bus.s_ready = s_ready_s;
   assign bus.m_data  = m_data_q;
   assign bus.m_sat   = m_sat_q;
   assign bus.m_count = m_count_q;
   assign bus.m_valid = m_valid_q;
endmodule

// File: tb/tb_mac_acc_quant.sv
// Randomised and directed bench for mac_acc_quant with a frame-level arithmetic reference model.
module tb_mac_acc_quant;
   localparam int PW = 28;
   localparam int OW = 14;
   localparam int CNT_W = 16;
   localparam int SH = 8;
   localparam longint AMAX = (64'sd1 <<< 35) - 64'sd1;
   localparam longint AMIN = -(64'sd1 <<< 35);

   logic clock;
   logic rstn;
   mac_acc_quant_if #(.PW(PW), .OW(OW), .CNT_W(CNT_W)) bus ();

   mac_acc_quant dut (
      .clock (clock),
      .rstn  (rstn),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int vectors = 0;
   int miscompares = 0;
   int rdy_mode = 0;

   longint exp_data[$];
   longint exp_cnt[$];
   longint exp_sat[$];

   longint acc_m;
   longint cnt_m;
   bit     ovf_m;
   bit     open_m;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      acc_m = 0; cnt_m = 0; ovf_m = 1'b0; open_m = 1'b0;
   endtask

   task automatic model_accept(input longint p, input bit last);
      longint s, q;
      bit clip;
      if (!open_m) begin
         acc_m = 0; ovf_m = 1'b0; cnt_m = 0;
      end
      cnt_m = (cnt_m == 65535) ? 65535 : cnt_m + 1;
      s = acc_m + p;
      if (s > AMAX) begin s = AMAX; ovf_m = 1'b1; end
      else if (s < AMIN) begin s = AMIN; ovf_m = 1'b1; end
      if (last) begin
`ifdef MAC_ACC_ROUND_EN
         s = s + (64'sd1 <<< (SH - 1));
`endif
         q = s >>> SH;
         clip = 1'b0;
         if (q > 8191) begin q = 8191; clip = 1'b1; end
         else if (q < -8192) begin q = -8192; clip = 1'b1; end
         exp_data.push_back(q & 64'h3FFF);
         exp_cnt.push_back(cnt_m);
         exp_sat.push_back(longint'(clip | ovf_m));
         open_m = 1'b0;
         acc_m = 0;
      end else begin
         acc_m = s;
         open_m = 1'b1;
      end
   endtask

   task automatic send(input longint p, input bit last);
      logic [63:0] pv;
      int waitc = 0;
      bit done = 1'b0;
      pv = p;
      bus.s_product = pv[PW-1:0];
      bus.s_last = last;
      bus.s_valid = 1'b1;
      while (!done) begin
         @(negedge clock);
         if (bus.s_ready) begin
            @(posedge clock);
            #1;
            done = 1'b1;
         end else begin
            waitc++;
            if (waitc > 1000) begin
               check_val("s_ready_timeout", 64'(bus.s_ready), 64'd1);
               done = 1'b1;
            end
         end
      end
      bus.s_valid = 1'b0;
      bus.s_last = 1'b0;
      if (waitc <= 1000) begin
         model_accept(p, last);
         if (last) check_val("m_valid_latency", 64'(bus.m_valid), 64'd1);
      end
   endtask

   task automatic send_frame(input longint p, input int n);
      for (int i = 0; i < n; i++) send(p, i == n - 1);
   endtask

   task automatic drain();
      int n = 0;
      rdy_mode = 0;
      while (exp_data.size() > 0 && n < 2000) begin
         @(posedge clock);
         n++;
      end
      #1;
      check_val("drain_empty", 64'(exp_data.size()), 64'd0);
   endtask

   // Output ready pattern, updated just after each rising edge.
   initial begin
      bus.m_ready = 1'b1;
      forever begin
         @(posedge clock);
         #1;
         case (rdy_mode)
            0: bus.m_ready = 1'b1;
            1: bus.m_ready = ($urandom_range(0, 3) != 0);
            default: bus.m_ready = 1'b0;
         endcase
      end
   end

   // Scoreboard: retire each output beat on the edge where valid and ready meet.
   initial begin
      forever begin
         @(negedge clock);
         if (rstn && bus.m_valid && !bus.m_ready)
            check_val("s_ready_backpressure", 64'(bus.s_ready), 64'd0);
         if (rstn && bus.m_valid && bus.m_ready) begin
            if (exp_data.size() == 0) begin
               check_val("unexpected_output", 64'd1, 64'd0);
            end else begin
               check_val("m_data", 64'(bus.m_data), exp_data.pop_front());
               check_val("m_count", 64'(bus.m_count), exp_cnt.pop_front());
               check_val("m_sat", 64'(bus.m_sat), exp_sat.pop_front());
            end
         end
      end
   end

   initial begin
      logic signed [PW-1:0] rs;
      longint p;
      int len;
      bus.s_valid = 1'b0;
      bus.s_last = 1'b0;
      bus.s_product = '0;
      model_reset();
      rstn = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      check_val("rst_m_valid", 64'(bus.m_valid), 64'd0);
      check_val("rst_m_data", 64'(bus.m_data), 64'd0);
      check_val("rst_m_count", 64'(bus.m_count), 64'd0);
      check_val("rst_m_sat", 64'(bus.m_sat), 64'd0);
      check_val("rst_s_ready", 64'(bus.s_ready), 64'd1);
      rstn = 1'b1;
      @(posedge clock);
      #1;

      send_frame(65536, 3);
      drain();
      send_frame(65536, 40);
      send_frame(-65536, 40);
      send(128, 1'b1);
      send(-128, 1'b1);
      drain();

      rdy_mode = 2;
      fork
         begin
            send(256, 1'b1);
            send(512, 1'b1);
            send(768, 1'b1);
         end
         begin
            repeat (5) @(posedge clock);
            rdy_mode = 0;
         end
      join
      drain();

      send(65536, 1'b0);
      send(65536, 1'b0);
      rstn = 1'b0;
      model_reset();
      #1;
      check_val("midrst_m_valid", 64'(bus.m_valid), 64'd0);
      check_val("midrst_s_ready", 64'(bus.s_ready), 64'd1);
      repeat (2) @(posedge clock);
      #1;
      rstn = 1'b1;
      @(posedge clock);
      #1;
      send(65536, 1'b1);
      drain();

      send_frame((64'sd1 <<< 27) - 64'sd1, 300);
      send(65536, 1'b1);
      drain();

      rdy_mode = 1;
      for (int f = 0; f < 40; f++) begin
         len = $urandom_range(1, 8);
         for (int b = 0; b < len; b++) begin
            rs = PW'($urandom);
            p = rs;
            if ($urandom_range(0, 1) == 0) p = p >>> $urandom_range(4, 16);
            send(p, b == len - 1);
            if ($urandom_range(0, 3) == 0) begin
               repeat ($urandom_range(1, 3)) @(posedge clock);
               #1;
            end
         end
      end
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/mac_acc_quant.md
# mac_acc_quant

Downstream stage of the MAC datapath. It consumes the full-width signed product stream from the MAC's AXI-stream output, accumulates products across a frame delimited by `last`, then rounds and saturates the sum to a narrower Q format. It emits one registered AXI-stream beat per frame to the next consumer.

## Interface
Parameters:
- `int_a`, default 6: integer bits of operand A.
- `frac_a`, default 8: fraction bits of operand A.
- `int_b`, default 6: integer bits of operand B.
- `frac_b`, default 8: fraction bits of operand B.
- `out_int`, default 6: integer bits of the output word, sign included.
- `out_frac`, default 8: fraction bits of the output word. Must satisfy `out_frac <= frac_a+frac_b`.
- `ACC_GUARD`, default 8: extra accumulator MSBs.
- `CNT_W`, default 16: width of the beat counter.

Derived widths:
- PW = `int_a+frac_a+int_b+frac_b`; the input is Q(`int_a+int_b`).(`frac_a+frac_b`).
- AW = PW+`ACC_GUARD`.
- OW = `out_int+out_frac`.
- SH = `frac_a+frac_b-out_frac`.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `clock` in 1: sole clock, rising edge.
  - `rstn` in 1: asynchronous, active-low reset.
- Input stream, from the MAC:
  - `s_product` in PW: signed product.
  - `s_valid` in 1: product valid.
  - `s_last` in 1: final beat of the frame.
  - `s_ready` out 1: stage can accept.
- Output stream:
  - `m_data` out OW: signed, rounded, saturated frame sum.
  - `m_sat` out 1: result was clipped, or the accumulator overflowed.
  - `m_count` out CNT_W: beats in the frame; saturates at all-ones.
  - `m_valid` out 1: output beat valid.
  - `m_ready` in 1: consumer ready.

## Operation
- State machine:
  - IDLE: no frame in progress.
  - ACCUM: a frame is open.
  - A handshake with `s_last`=0 moves to or stays in ACCUM. A handshake with `s_last`=1 returns to IDLE. A single-beat frame goes IDLE→IDLE.
- Accumulation:
  - On a handshake (`s_valid && s_ready`), form `sum = base + sext(s_product)`, where `base` is 0 in IDLE and `acc` in ACCUM.
  - The beat counter loads 1 in IDLE, otherwise increments, holding at all-ones.
- Accumulator overflow:
  - Detected as signed overflow of the AW-bit add.
  - On overflow, `acc` clamps to the AW extreme matching the sign of `s_product`, and a frame-sticky `ovf` flag is set.
  - `ovf` is cleared at the first beat of the next frame.
- Quantisation, applied on the last beat to the final `sum`:
  - Rounding is optional; see Configuration.
  - Arithmetic right shift by SH.
  - Clamp to [-2^(OW-1), 2^(OW-1)-1].
- Output register:
  - Loads `m_data`, `m_count`, and `m_sat = clipped || ovf` on the last handshake, and sets `m_valid`.
  - `m_valid` clears on `m_ready` unless a new last beat loads in the same cycle.
- `s_ready = !m_valid || m_ready`, combinational. Non-last beats are also gated by this rule, which keeps the control simple.
- Reset, asynchronous, including mid-frame: all of the following are zero, the state is IDLE, and any partial frame is discarded:
  - `m_valid`, `m_data`, `m_sat`, `m_count`
  - `acc`, the beat counter, `ovf`
- `s_ready` is 1 immediately after reset.

## Timing
- Throughput: one input beat per cycle. A first beat of the next frame is accepted in the cycle after a `last` beat.
- Latency: a last beat accepted at edge N gives `m_valid`=1 after edge N.
- Simultaneous events, with `m_valid`=1, `m_ready`=1 and a new last beat at the same edge: the old beat retires and the new one loads. `m_valid` stays 1 with no bubble.
- Backpressure: while `m_valid`=1 and `m_ready`=0, `s_ready`=0 and the output holds stable (AXI rule). Upstream must hold its beat.
- `s_valid`=0 in ACCUM leaves all state unchanged. There is no frame timeout.

## Configuration
- `MAC_ACC_ROUND_EN` defined: round half-up. Add 2^(SH-1) before the shift when SH>0. The adder is AW+1 bits, so the addition itself never wraps.
- Undefined: truncate, i.e. floor via arithmetic shift, with no rounding adder.

## Test plan
All values use the default parameters: PW=28, SH=8, OW=14, so 1.0 in = 65536 and 1.0 out = 256.
- 3-beat frame of 65536 each, `m_ready`=1 → one beat: `m_data`=768, `m_count`=3, `m_sat`=0, `m_valid` one cycle after the last beat.
- 40 beats of +65536 → `m_data`=8191, `m_sat`=1. 40 beats of -65536 → `m_data`=-8192 (0x2000), `m_sat`=1.
- Single beat 128 → `m_data`=1 with `MAC_ACC_ROUND_EN`, 0 without. Single beat -128 → 0 with, -1 (0x3FFF) without.
- Back-to-back single-beat frames 256, 512, 768, `m_ready` low for 4 cycles, then high:
  - Expected outputs, in order with none lost: `m_data`=1, 2, 3.
  - `s_ready` is 0 while the output is full and stalled.
- Assert `rstn`=0 mid-frame after 2 beats of 65536, release, then send a 1-beat frame of 65536 → `m_data`=256, `m_count`=1.
- 300 beats of 2^27-1 → accumulator clamps, `m_sat`=1, `m_data`=8191, `m_count`=300. The next frame of one beat of 65536 gives `m_sat`=0.
